// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for the sequential ALU.
// Both sides use valid/ready: a transfer happens on a rising clock edge where
// valid and ready are both high; valid holds its payload steady until then,
// and ready may change freely without depending on the other side's valid.
`timescale 1ns/1ps
interface alu_seq_if #(
    parameter int N = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   ALUControl;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         zero;
    logic [3:0]   flags;
    logic         exc;
    logic [1:0]   exc_cause;

    // Upstream/downstream side of the ALU (decode stage + writeback).
    modport master (
        output in_valid, a, b, ALUControl, out_ready,
        input  in_ready, out_valid, result, zero, flags, exc, exc_cause
    );

    // The ALU itself.
    modport slave (
        input  in_valid, a, b, ALUControl, out_ready,
        output in_ready, out_valid, result, zero, flags, exc, exc_cause
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle LEGv8 ALU: single-cycle logic/add/sub/pass, iterative
// shift-add multiply and restoring divide, NZCV flags and exception cause.
`timescale 1ns/1ps
module alu_seq #(
    parameter int N        = 64,
    parameter bit TRAP_OVF = 1'b1
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus,
    output logic [1:0] state_o
);
    localparam int CW = $clog2(N + 1);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_UDIV  = 4'b1001;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_OVF  = 2'b01;
    localparam logic [1:0] CAUSE_DIV0 = 2'b10;
    localparam logic [1:0] CAUSE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_div_q, is_div_d;
    // opa: multiplicand (shifts left) or divisor (fixed).
    // opb: multiplier (shifts right) or dividend that turns into the quotient.
    // acc: partial product or partial remainder.
    logic [N-1:0]  opa_q, opa_d;
    logic [N-1:0]  opb_q, opb_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  result_q, result_d;
    logic [3:0]    flags_q, flags_d;
    logic          exc_q, exc_d;
    logic [1:0]    cause_q, cause_d;

    // Single-cycle datapath results
    logic [N-1:0]  b_add;
    logic [N:0]    sum;
    logic [N-1:0]  sc_res;
    logic          sc_c, sc_v, sc_ill;

    // Iterative step results
    logic [N-1:0]  mul_acc;
    logic [N:0]    rem_sh, rem_diff;
    logic          div_ge;
    logic [N-1:0]  rem_nx, quo_nx, fin;

    // Single-cycle ops straight off the input bus; SUB is a + ~b + 1.
    always_comb begin
        b_add  = (bus.ALUControl == OP_SUB) ? ~bus.b : bus.b;
        sum    = {1'b0, bus.a} + {1'b0, b_add} + {{N{1'b0}}, (bus.ALUControl == OP_SUB)};
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_ill = 1'b0;
        case (bus.ALUControl)
            OP_AND:   sc_res = bus.a & bus.b;
            OP_OR:    sc_res = bus.a | bus.b;
            OP_ADD: begin
                sc_res = sum[N-1:0];
                sc_c   = sum[N];
                sc_v   = (bus.a[N-1] == bus.b[N-1]) && (sum[N-1] != bus.a[N-1]);
            end
            OP_SUB: begin
                sc_res = sum[N-1:0];
                sc_c   = sum[N];
                sc_v   = (bus.a[N-1] != bus.b[N-1]) && (sum[N-1] != bus.a[N-1]);
            end
            OP_PASSB: sc_res = bus.b;
            OP_MUL, OP_UDIV: sc_ill = 1'b0;
            default:  sc_ill = 1'b1;
        endcase
    end

    // One multiply bit or one quotient bit per cycle.
    always_comb begin
        mul_acc  = acc_q + (opb_q[0] ? opa_q : '0);
        rem_sh   = {acc_q, opb_q[N-1]};
        rem_diff = rem_sh - {1'b0, opa_q};
        div_ge   = ~rem_diff[N];
        rem_nx   = div_ge ? rem_diff[N-1:0] : rem_sh[N-1:0];
        quo_nx   = {opb_q[N-2:0], div_ge};
        fin      = is_div_q ? quo_nx : mul_acc;
    end

    // Next-state and datapath update; everything holds unless a branch moves it.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        result_d = result_q;
        flags_d  = flags_q;
        exc_d    = exc_q;
        cause_d  = cause_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.ALUControl == OP_MUL) begin
                        state_d  = S_BUSY;
                        cnt_d    = CW'(N);
                        is_div_d = 1'b0;
                        opa_d    = bus.a;
                        opb_d    = bus.b;
                        acc_d    = '0;
                    end else if (bus.ALUControl == OP_UDIV && bus.b != '0) begin
                        state_d  = S_BUSY;
                        cnt_d    = CW'(N);
                        is_div_d = 1'b1;
                        opa_d    = bus.b;
                        opb_d    = bus.a;
                        acc_d    = '0;
                    end else if (bus.ALUControl == OP_UDIV) begin
                        state_d  = S_DONE;
                        result_d = '1;
                        flags_d  = 4'b1000;
                        exc_d    = 1'b1;
                        cause_d  = CAUSE_DIV0;
                    end else begin
                        state_d  = S_DONE;
                        result_d = sc_res;
                        flags_d  = {sc_res[N-1], (sc_res == '0), sc_c, sc_v};
                        if (sc_ill) begin
                            exc_d   = 1'b1;
                            cause_d = CAUSE_ILL;
                        end else if (sc_v && TRAP_OVF) begin
                            exc_d   = 1'b1;
                            cause_d = CAUSE_OVF;
                        end else begin
                            exc_d   = 1'b0;
                            cause_d = CAUSE_NONE;
                        end
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (is_div_q) begin
                    acc_d = rem_nx;
                    opb_d = quo_nx;
                end else begin
                    acc_d = mul_acc;
                    opa_d = opa_q << 1;
                    opb_d = opb_q >> 1;
                end
                // The last step lands its value directly in the result register.
                if (cnt_q == CW'(1)) begin
                    state_d  = S_DONE;
                    result_d = fin;
                    flags_d  = {fin[N-1], (fin == '0), 2'b00};
                    exc_d    = 1'b0;
                    cause_d  = CAUSE_NONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            exc_q    <= 1'b0;
            cause_q  <= CAUSE_NONE;
        end else begin
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            exc_q    <= exc_d;
            cause_q  <= cause_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign bus.zero      = flags_q[2];
    assign bus.exc       = exc_q;
    assign bus.exc_cause = cause_q;
    assign state_o       = state_q;
endmodule
